word_splitter: RTL and testbench
================================

// Module: word_splitter
//
// PURPOSE
// - Inverse of the adder tree's NUM-to-1 reduction: takes one beat of NUM packed BITS-wide words
//   and emits them one word per accepted output beat, index 0 first.
// - Sits ahead of a single-lane consumer, such as a 2-input adder or a narrow bus, that cannot
//   accept NUM words at once.
// - Handshake: valid/ready on both sides; back-to-back input beats run with no bubble.
//
// PARAMETERS
// - BITS  16  width of one word
// - NUM    4  words per input beat (>=1)
// - IDXW  $clog2(NUM) (min 1)  width of idx output; derived, not overridden
//
// PORTS
// - clk        input   1          clock, rising edge
// - resetn     input   1          asynchronous active-low reset
// - valid      input   1          input beat valid
// - in_ready   output  1          splitter can accept an input beat this cycle
// - i          input   BITS*NUM   packed words; word k = i[k*BITS +: BITS]
// - o          output  BITS       current output word
// - valid_out  output  1          o / idx / last valid
// - ready      input   1          downstream accepts the output beat
// - idx        output  IDXW       index of the word on o
// - last       output  1          word on o is word NUM-1 of its beat
//
// BEHAVIOUR
// - Reset (resetn low, async): valid_out=0, o=0, idx=0, last=0, buffer cleared, FSM=IDLE.
//   - in_ready=0 while resetn is low.
//   - Any beat in flight is discarded; it is not resumed after reset.
// - Accept rule: an input beat is taken on an edge where valid & in_ready.
//   Output beat rule: a word is transferred on an edge where valid_out & ready.
// - in_ready = (state==IDLE) | (state==SEND & last & ready). Combinational from state and ready only;
//   never depends on valid.
// - FSM:
//   - IDLE: on accept, load buffer <= i, o <= word 0, idx <= 0, last <= (NUM==1), valid_out <= 1,
//     then go to SEND.
//   - SEND, valid_out & !ready: o, idx, last and valid_out hold stable (stall).
//   - SEND, transfer with !last: idx <= idx+1, o <= word idx+1, last <= (idx+1==NUM-1).
//   - SEND, transfer with last and valid: reload from i as in IDLE (zero bubble); stay in SEND.
//   - SEND, transfer with last and !valid: valid_out <= 0, idx <= 0, last <= 0, go to IDLE.
// - Latency: input accepted at edge k -> word 0 valid after edge k. An uninterrupted beat takes
//   exactly NUM cycles of valid_out.
// - Throughput: 1 word per cycle when ready is held high.
// - o is registered, with no combinational path from i to o. It is a verbatim copy with no
//   arithmetic; all BITS bits pass unchanged.
// - Input is ignored whenever in_ready=0. Upstream must hold i stable until accepted; the
//   splitter does not sample i otherwise.
// - NUM==1: every output word has last=1 and idx=0; the block degenerates to a 1-deep skid-free
//   register stage.
// - idx counts only 0..NUM-1 and never exceeds NUM-1, including for non-power-of-2 NUM.
//
// TESTING
// - Single beat: BITS=16, NUM=4, i={16'h0004,16'h0003,16'h0002,16'h0001}, ready=1.
//   Required: o=1,2,3,4 on 4 consecutive cycles; idx=0..3; last only with 4; then valid_out=0.
// - Back-to-back: two beats {1,2,3,4} then {5,6,7,8}, valid held high, ready=1.
//   Required: 8 consecutive valid words 1..8 with no gap; in_ready=1 only on the cycles showing
//   4 and 8 (and in IDLE).
// - Backpressure: ready=0 for 3 cycles while o=2.
//   Required: o=2, idx=1 and valid_out=1 held; in_ready=0 throughout; the sequence resumes with 3.
// - Reset mid-beat: assert resetn=0 while o=3 (idx=2).
//   Required: valid_out, o, idx and last drop to 0 immediately; after release a new beat {9,10,11,12}
//   emits 9 first.
// - Parameter corners: NUM=1, BITS=8 -> each beat gives one word with last=1, idx=0.
//   NUM=3 -> idx runs 0,1,2 and wraps to 0, never reaches 3.
// - Random: valid and ready toggle with 50% probability for 10k cycles.
//   Required: the output word stream equals the input beats flattened word 0 first; no loss or
//   duplication.

Source files
------------

// File: rtl/word_splitter.sv
// Serialises one beat of NUM packed BITS-wide words into NUM output beats, word 0 first.
// Holds the input beat in a buffer so back-to-back beats stream without a bubble.
module word_splitter #(
  parameter  int BITS = 16,
  parameter  int NUM  = 4,
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid,
  output logic                 in_ready,
  input  logic [BITS*NUM-1:0]  i,
  output logic [BITS-1:0]      o,
  output logic                 valid_out,
  input  logic                 ready,
  output logic [IDXW-1:0]      idx,
  output logic                 last,
  output logic                 dbg_send
);

  // Handshake: a beat moves on an edge where its valid and ready are both high;
  // in_ready is a function of state, last and ready only, never of valid.
  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_n;
  logic [BITS*NUM-1:0]   buffer;
  logic [BITS-1:0]       o_n, word_next;
  logic [IDXW-1:0]       idx_n, idx_inc;
  logic                  last_n, valid_out_n, load, accept, xfer;

  assign in_ready = resetn & ((state == IDLE) | ((state == SEND) & last & ready));
  assign accept   = valid & in_ready;
  assign xfer     = valid_out & ready;
  assign idx_inc  = idx + 1'b1;
  assign dbg_send = (state == SEND);

  // idx_inc only selects a word while last is low, so it stays within 1..NUM-1.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < NUM; k++) begin
      if (idx_inc == IDXW'(k)) word_next = buffer[k*BITS +: BITS];
    end
  end

  always_comb begin
    state_n     = state;
    o_n         = o;
    idx_n       = idx;
    last_n      = last;
    valid_out_n = valid_out;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load        = 1'b1;
          o_n         = i[BITS-1:0];
          idx_n       = '0;
          last_n      = (NUM == 1);
          valid_out_n = 1'b1;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (xfer && !last) begin
          idx_n  = idx_inc;
          o_n    = word_next;
          last_n = (idx_inc == IDXW'(NUM - 1));
        end else if (xfer && accept) begin
          // Final word leaves while the next beat is taken: reload with no gap.
          load        = 1'b1;
          o_n         = i[BITS-1:0];
          idx_n       = '0;
          last_n      = (NUM == 1);
          valid_out_n = 1'b1;
        end else if (xfer) begin
          valid_out_n = 1'b0;
          idx_n       = '0;
          last_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      buffer    <= '0;
      o         <= '0;
      idx       <= '0;
      last      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      o         <= o_n;
      idx       <= idx_n;
      last      <= last_n;
      valid_out <= valid_out_n;
      if (load) buffer <= i;
    end
  end

endmodule

// File: tb/tb_word_splitter.sv
// Directed and random checks of word_splitter: default NUM=4, plus NUM=1 and NUM=3 corners.
module tb_word_splitter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // NUM=4, BITS=16
  logic        valid = 1'b0, ready = 1'b0;
  logic [63:0] i = '0;
  logic        in_ready, valid_out, last, dbg;
  logic [15:0] o;
  logic [1:0]  idx;

  // NUM=1, BITS=8
  logic        v1 = 1'b0, r1 = 1'b0;
  logic [7:0]  i1 = '0;
  logic        ir1, vo1, l1, d1;
  logic [7:0]  o1;
  logic [0:0]  idx1;

  // NUM=3, BITS=16
  logic        v3 = 1'b0, r3 = 1'b0;
  logic [47:0] i3 = '0;
  logic        ir3, vo3, l3, d3;
  logic [15:0] o3;
  logic [1:0]  idx3;

  int checks = 0;
  int failures = 0;
  logic [18:0] exp_q[$];

  word_splitter #(.BITS(16), .NUM(4)) u_dut (
    .clk(clk), .resetn(resetn), .valid(valid), .in_ready(in_ready), .i(i), .o(o),
    .valid_out(valid_out), .ready(ready), .idx(idx), .last(last), .dbg_send(dbg));

  word_splitter #(.BITS(8), .NUM(1)) u_n1 (
    .clk(clk), .resetn(resetn), .valid(v1), .in_ready(ir1), .i(i1), .o(o1),
    .valid_out(vo1), .ready(r1), .idx(idx1), .last(l1), .dbg_send(d1));

  word_splitter #(.BITS(16), .NUM(3)) u_n3 (
    .clk(clk), .resetn(resetn), .valid(v3), .in_ready(ir3), .i(i3), .o(o3),
    .valid_out(vo3), .ready(r3), .idx(idx3), .last(l3), .dbg_send(d3));

  task test_reset;
    resetn = 1'b0;
    #12;
    @(negedge clk);
    checks++;
    if ({valid_out, o, idx, last, in_ready, dbg} !== 22'h0) begin
      failures++;
      $display("FAIL reset_main got=%h exp=0", {valid_out, o, idx, last, in_ready, dbg});
    end
    checks++;
    if ({vo1, o1, idx1, l1, ir1, vo3, o3, idx3, l3, ir3} !== 33'h0) begin
      failures++;
      $display("FAIL reset_corners got=%h exp=0", {vo1, o1, idx1, l1, ir1, vo3, o3, idx3, l3, ir3});
    end
    resetn = 1'b1;
    #1;
    checks++;
    if ({in_ready, ir1, ir3, valid_out} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_release got=%b exp=1110", {in_ready, ir1, ir3, valid_out});
    end
  endtask

  task test_single_beat;
    logic [20:0] exp;
    @(negedge clk);
    valid = 1'b1; i = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; ready = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) valid = 1'b0;
      #1;
      exp = {1'b1, 16'(n + 1), 2'(n), (n == 3), (n == 3)};
      checks++;
      if ({valid_out, o, idx, last, in_ready} !== exp) begin
        failures++;
        $display("FAIL single_beat_w%0d got=%h exp=%h", n, {valid_out, o, idx, last, in_ready}, exp);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({valid_out, in_ready, last, idx} !== 5'b01000) begin
      failures++;
      $display("FAIL single_beat_idle got=%b exp=01000", {valid_out, in_ready, last, idx});
    end
  endtask

  task test_back_to_back;
    logic [20:0] exp;
    @(negedge clk);
    valid = 1'b1; i = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; ready = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 0) i = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
      if (n == 4) valid = 1'b0;
      #1;
      exp = {1'b1, 16'(n + 1), 2'(n % 4), (n % 4 == 3), (n % 4 == 3)};
      checks++;
      if ({valid_out, o, idx, last, in_ready} !== exp) begin
        failures++;
        $display("FAIL back_to_back_w%0d got=%h exp=%h", n, {valid_out, o, idx, last, in_ready}, exp);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({valid_out, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL back_to_back_idle got=%b exp=01", {valid_out, in_ready});
    end
  endtask

  task test_backpressure;
    logic [20:0] exp;
    @(negedge clk);
    valid = 1'b1; i = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({valid_out, o, idx, last, in_ready} !== {1'b1, 16'h0002, 2'd1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure_c%0d got=%h exp=%h", c, {valid_out, o, idx, last, in_ready},
                 {1'b1, 16'h0002, 2'd1, 1'b0, 1'b0});
      end
      if (c < 3) @(negedge clk);
    end
    ready = 1'b1;
    for (int n = 2; n < 4; n++) begin
      @(negedge clk); #1;
      exp = {1'b1, 16'(n + 1), 2'(n), (n == 3), (n == 3)};
      checks++;
      if ({valid_out, o, idx, last, in_ready} !== exp) begin
        failures++;
        $display("FAIL backpressure_resume_w%0d got=%h exp=%h", n, {valid_out, o, idx, last, in_ready}, exp);
      end
    end
    @(negedge clk);
  endtask

  task test_reset_mid_beat;
    @(negedge clk);
    valid = 1'b1; i = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o, idx} !== {16'h0003, 2'd2}) begin
      failures++;
      $display("FAIL reset_mid_pre got=%h exp=%h", {o, idx}, {16'h0003, 2'd2});
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({valid_out, o, idx, last, in_ready} !== 21'h0) begin
      failures++;
      $display("FAIL reset_mid_drop got=%h exp=0", {valid_out, o, idx, last, in_ready});
    end
    @(negedge clk);
    resetn = 1'b1;
    valid = 1'b1; i = {16'd12, 16'd11, 16'd10, 16'd9};
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    #1;
    checks++;
    if ({valid_out, o, idx, last} !== {1'b1, 16'd9, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_restart got=%h exp=%h", {valid_out, o, idx, last}, {1'b1, 16'd9, 2'd0, 1'b0});
    end
    repeat (4) @(negedge clk);
  endtask

  task test_num1;
    @(negedge clk);
    v1 = 1'b1; i1 = 8'hA5; r1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i1 = 8'h3C;
    #1;
    checks++;
    if ({vo1, o1, idx1, l1, ir1} !== {1'b1, 8'hA5, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL num1_w0 got=%h exp=%h", {vo1, o1, idx1, l1, ir1}, {1'b1, 8'hA5, 1'b0, 1'b1, 1'b1});
    end
    @(negedge clk);
    v1 = 1'b0;
    #1;
    checks++;
    if ({vo1, o1, idx1, l1} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL num1_w1 got=%h exp=%h", {vo1, o1, idx1, l1}, {1'b1, 8'h3C, 1'b0, 1'b1});
    end
    @(negedge clk); #1;
    checks++;
    if ({vo1, ir1} !== 2'b01) begin
      failures++;
      $display("FAIL num1_idle got=%b exp=01", {vo1, ir1});
    end
  endtask

  task test_num3;
    logic [19:0] exp;
    @(negedge clk);
    v3 = 1'b1; i3 = {16'd3, 16'd2, 16'd1}; r3 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) i3 = {16'd6, 16'd5, 16'd4};
      if (n == 3) v3 = 1'b0;
      #1;
      exp = {1'b1, 16'(n + 1), 2'(n % 3), (n % 3 == 2)};
      checks++;
      if ({vo3, o3, idx3, l3} !== exp) begin
        failures++;
        $display("FAIL num3_w%0d got=%h exp=%h", n, {vo3, o3, idx3, l3}, exp);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({vo3, idx3, ir3} !== 4'b0001) begin
      failures++;
      $display("FAIL num3_idle got=%b exp=0001", {vo3, idx3, ir3});
    end
  endtask

  task test_random;
    logic        acc;
    logic [18:0] e;
    acc = 1'b0;
    @(negedge clk);
    valid = 1'b0; ready = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      // Upstream holds a pending beat until it is taken.
      if (!valid || acc) begin
        valid = 1'($urandom_range(0, 1));
        i = {$urandom, $urandom};
      end
      ready = 1'($urandom_range(0, 1));
      #1;
      acc = valid & in_ready;
      if (acc) for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), 2'(k), i[k*16 +: 16]});
      if (valid_out && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_extra_word got=%h exp=none", {last, idx, o});
        end else begin
          e = exp_q.pop_front();
          if ({last, idx, o} !== e) begin
            failures++;
            $display("FAIL random_word c=%0d got=%h exp=%h", c, {last, idx, o}, e);
          end
        end
      end
    end
    @(negedge clk);
    valid = 1'b0; ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_drain_extra got=%h exp=none", {last, idx, o});
        end else begin
          e = exp_q.pop_front();
          if ({last, idx, o} !== e) begin
            failures++;
            $display("FAIL random_drain got=%h exp=%h", {last, idx, o}, e);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL random_leftover got=%0d words vout=%b exp=0 words vout=0", exp_q.size(), valid_out);
    end
  endtask

  initial begin
    test_reset;
    test_single_beat;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_beat;
    test_num1;
    test_num3;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
